// File: rtl/uart_rx_monitor_if.sv
// Receive-side bus of uart_rx_monitor: serial input, FWFT FIFO read port,
// status and sticky error flags. The slave modport is the receiver, the
// master modport is whoever drives rx and drains the FIFO.
interface uart_rx_monitor_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          rx;
  logic                          rd_en;
  logic                          clear_err;
  logic [DATA_BITS-1:0]          rd_data;
  logic                          rd_valid;
  logic                          full;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          busy;
  logic                          frame_err;
  logic                          parity_err;
  logic                          overrun;

  modport slave (
    input  rx, rd_en, clear_err,
    output rd_data, rd_valid, full, count, busy, frame_err, parity_err, overrun
  );

  modport master (
    output rx, rd_en, clear_err,
    input  rd_data, rd_valid, full, count, busy, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: mid-bit sampling UART receiver feeding a first-word-fall-
// through byte FIFO, with sticky frame/parity/overrun flags.
// Optional build macro UART_RX_MON_DISPLAY_EN adds a simulation-only block
// that prints received bytes and error events; outputs are unaffected.
module uart_rx_monitor #(
  parameter int CLK_DIV    = 106,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_rx_monitor_if.slave  bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser and edge history
  logic sync1, sync2, rx_prev;
  logic rx_s;

  // Frame FSM
  state_t               state, state_n;
  logic [CNT_W-1:0]     div_cnt, div_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 push_req, frame_ev, parity_ev;

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 pop, push, overrun_ev, fifo_full;

  assign rx_s = sync2;

  // Two-flop synchroniser plus one history flop for falling-edge detect;
  // all preset high so reset never manufactures a start edge.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= bus.rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // FSM state, bit timing and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
    end
  end

  // Next-state logic: sample the line once per bit and flag completion.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_n   = state;
    div_n     = div_cnt + 1'b1;
    bit_n     = bit_cnt;
    shift_n   = shift;
    perr_n    = perr_q;
    ferr_n    = ferr_q;
    push_req  = 1'b0;
    frame_ev  = 1'b0;
    parity_ev = 1'b0;

    unique case (state)
      S_IDLE: begin
        div_n  = '0;
        bit_n  = '0;
        perr_n = 1'b0;
        ferr_n = 1'b0;
        if (rx_prev && !rx_s) state_n = S_START;
      end

      S_START: begin
        if (div_cnt == HALF_LAST) begin
          div_n   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (div_cnt == FULL_LAST) begin
          div_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (div_cnt == FULL_LAST) begin
          div_n   = '0;
          // Odd parity needs an odd total of ones, even parity an even one.
          perr_n  = (PARITY == 1) ? ~((^shift) ^ rx_s) : ((^shift) ^ rx_s);
          state_n = S_STOP;
        end
      end

      S_STOP: begin
        if (div_cnt == FULL_LAST) begin
          div_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n     = '0;
            frame_ev  = ferr_q | ~rx_s;
            parity_ev = perr_q;
            push_req  = ~(ferr_q | ~rx_s) & ~perr_q;
            state_n   = (ferr_q | ~rx_s) ? S_BREAK : S_IDLE;
          end else begin
            ferr_n = ferr_q | ~rx_s;
            bit_n  = bit_cnt + 1'b1;
          end
        end
      end

      S_BREAK: begin
        // Wait out a held-low line so it yields a single frame error.
        div_n = '0;
        if (rx_s) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign pop        = bus.rd_en && (count_q != '0);
  assign push       = push_req && (!fifo_full || bus.rd_en);
  assign overrun_ev = push_req && fifo_full && !bus.rd_en;

  // FIFO storage; written only, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset on purpose: entries are only readable
    // once written, and rd_data is forced to zero while the FIFO is empty.
    if (push) mem[wr_ptr] <= shift;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a set event outranks clear_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (frame_ev)           bus.frame_err <= 1'b1;
      else if (bus.clear_err) bus.frame_err <= 1'b0;
      if (parity_ev)          bus.parity_err <= 1'b1;
      else if (bus.clear_err) bus.parity_err <= 1'b0;
      if (overrun_ev)         bus.overrun <= 1'b1;
      else if (bus.clear_err) bus.overrun <= 1'b0;
    end
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;
  assign bus.full     = fifo_full;
  assign bus.count    = count_q;
  assign bus.busy     = (state != S_IDLE);

`ifdef UART_RX_MON_DISPLAY_EN
  // Simulation-only trace of received bytes and error events.
  always @(posedge clk) begin
    if (!reset) begin
      if (push) begin
        if (int'(shift) >= 32 && int'(shift) < 127)
          $display("uart_rx_monitor: '%c'", shift);
        else
          $display("uart_rx_monitor: %d", shift);
      end
      if (frame_ev)   $display("uart_rx_monitor: frame error at %0t", $time);
      if (parity_ev)  $display("uart_rx_monitor: parity error at %0t", $time);
      if (overrun_ev) $display("uart_rx_monitor: overrun at %0t", $time);
    end
  end
`else
  // No trace logic in the synthesis build.
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Testbench for uart_rx_monitor. Two instances: A with default parameters
// (8N1, CLK_DIV=106, 16-deep FIFO) and B with even parity, two stop bits,
// CLK_DIV=16 and a 4-deep FIFO. Expected bytes are queued when a clean frame
// is sent and compared when popped from the DUT.
module tb_uart_rx_monitor;

  localparam int C_A = 106;
  localparam int C_B = 16;

  logic clk = 1'b0;
  logic reset_a, reset_b;

  uart_rx_monitor_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_a ();
  uart_rx_monitor_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  bus_b ();

  uart_rx_monitor dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  uart_rx_monitor #(
    .CLK_DIV(C_B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- per-instance accessors (w=0 -> A, w=1 -> B) ----
  function automatic int cdiv(input int w);   return (w == 0) ? C_A : C_B; endfunction
  function automatic int nbits(input int w);  return (w == 0) ? 10 : 12;   endfunction
  function automatic int depth(input int w);  return (w == 0) ? 16 : 4;    endfunction
  function automatic logic get_valid(input int w);
    return (w == 0) ? bus_a.rd_valid : bus_b.rd_valid;
  endfunction
  function automatic logic [7:0] get_data(input int w);
    return (w == 0) ? bus_a.rd_data : bus_b.rd_data;
  endfunction
  function automatic int get_count(input int w);
    return (w == 0) ? int'(bus_a.count) : int'(bus_b.count);
  endfunction
  function automatic logic get_full(input int w);
    return (w == 0) ? bus_a.full : bus_b.full;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  // {frame_err, parity_err, overrun}
  function automatic logic [2:0] get_flags(input int w);
    return (w == 0) ? {bus_a.frame_err, bus_a.parity_err, bus_a.overrun}
                    : {bus_b.frame_err, bus_b.parity_err, bus_b.overrun};
  endfunction

  task automatic set_rx(input int w, input logic v);
    if (w == 0) bus_a.rx = v; else bus_b.rx = v;
  endtask
  task automatic set_rd_en(input int w, input logic v);
    if (w == 0) bus_a.rd_en = v; else bus_b.rd_en = v;
  endtask
  task automatic set_reset(input int w, input logic v);
    if (w == 0) reset_a = v; else reset_b = v;
  endtask

  function automatic int q_size(input int w);
    return (w == 0) ? q_a.size() : q_b.size();
  endfunction
  function automatic logic [7:0] q_front(input int w);
    if (q_size(w) == 0) return 8'h00;
    return (w == 0) ? q_a[0] : q_b[0];
  endfunction
  task automatic q_pop(input int w);
    if (q_size(w) != 0) begin
      if (w == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
    end
  endtask
  task automatic q_push(input int w, input logic [7:0] b);
    if (w == 0) q_a.push_back(b); else q_b.push_back(b);
  endtask
  task automatic q_clear(input int w);
    if (w == 0) q_a.delete(); else q_b.delete();
  endtask

  task automatic pulse_clear(input int w);
    if (w == 0) bus_a.clear_err = 1'b1; else bus_b.clear_err = 1'b1;
    tick();
    if (w == 0) bus_a.clear_err = 1'b0; else bus_b.clear_err = 1'b0;
    tick();
  endtask

  task automatic check_reset_state(input int w, input string tag);
    check({tag, "_valid"}, get_valid(w), 1'b0);
    check({tag, "_data"},  get_data(w),  8'h00);
    check({tag, "_count"}, get_count(w), 0);
    check({tag, "_full"},  get_full(w),  1'b0);
    check({tag, "_busy"},  get_busy(w),  1'b0);
    check({tag, "_flags"}, get_flags(w), 3'b000);
  endtask

  task automatic apply_reset(input int w);
    set_rx(w, 1'b1);
    set_rd_en(w, 1'b0);
    if (w == 0) bus_a.clear_err = 1'b0; else bus_b.clear_err = 1'b0;
    set_reset(w, 1'b1);
    tick();
    tick();
    set_reset(w, 1'b0);
    tick();
    q_clear(w);
  endtask

  // Send one frame. The final stop sample happens in the cycle before edge
  // fin (2-flop sync + edge detect + half bit + whole bits), so the byte is
  // in the FIFO right after edge fin.
  task automatic send_frame(input int w, input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input bit pop_at_end,
                            input bit chk_timing);
    logic bits [12];
    int   n, c, fin;
    bit   expect_push;
    n = nbits(w);
    c = cdiv(w);
    fin = 3 + c / 2 + (n - 1) * c;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    for (int i = 9; i < 12; i++) bits[i] = 1'b1;
    if (w == 1) bits[9] = (^d) ^ bad_par;
    if (bad_stop) bits[n - 1] = 1'b0;
    expect_push = !bad_par && !bad_stop && (q_size(w) < depth(w) || pop_at_end);

    tick();
    set_rx(w, bits[0]);
    for (int e = 1; e <= n * c; e++) begin
      tick();
      if (e % c == 0) set_rx(w, (e / c < n) ? bits[e / c] : 1'b1);
      if (chk_timing && e == fin - 1) check("valid_before_stop", get_valid(w), 1'b0);
      if (chk_timing && e == fin)     check("valid_after_stop",  get_valid(w), 1'b1);
      if (pop_at_end && e == fin - 1) begin
        check("pop_at_push_data", get_data(w), q_front(w));
        q_pop(w);
        set_rd_en(w, 1'b1);
      end
      if (pop_at_end && e == fin) set_rd_en(w, 1'b0);
    end
    if (expect_push) q_push(w, d);
  endtask

  // Pop everything, comparing against the scoreboard.
  task automatic drain(input int w, input string tag);
    check({tag, "_count"}, get_count(w), q_size(w));
    for (int k = 0; k < 20 && get_valid(w); k++) begin
      check({tag, "_data"}, get_data(w), q_front(w));
      q_pop(w);
      set_rd_en(w, 1'b1);
      tick();
      set_rd_en(w, 1'b0);
    end
    check({tag, "_empty"}, get_valid(w), (q_size(w) != 0));
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.rx = 1'b1; bus_a.rd_en = 1'b0; bus_a.clear_err = 1'b0;
    bus_b.rx = 1'b1; bus_b.rd_en = 1'b0; bus_b.clear_err = 1'b0;
    apply_reset(0);
    apply_reset(1);
    check_reset_state(0, "rst_a");
    check_reset_state(1, "rst_b");

    // Two clean 8N1 bytes, first with exact rd_valid timing.
    send_frame(0, 8'h41, 0, 0, 0, 1);
    send_frame(0, 8'h0A, 0, 0, 0, 0);
    check("t1_flags", get_flags(0), 3'b000);
    drain(0, "t1");

    // Short low glitch aborts in START.
    tick();
    set_rx(0, 1'b0);
    repeat (C_A / 4) tick();
    set_rx(0, 1'b1);
    repeat (2 * C_A) tick();
    check("glitch_busy",  get_busy(0),  1'b0);
    check("glitch_valid", get_valid(0), 1'b0);
    check("glitch_flags", get_flags(0), 3'b000);

    // Line held low for 20 bit times: one frame error, then BREAK.
    tick();
    set_rx(0, 1'b0);
    repeat (11 * C_A) tick();
    check("hold_flags", get_flags(0), 3'b100);
    check("hold_count", get_count(0), 0);
    check("hold_busy",  get_busy(0),  1'b1);
    pulse_clear(0);
    repeat (9 * C_A) tick();
    check("hold_no_repeat", get_flags(0), 3'b000);
    check("hold_break",     get_busy(0),  1'b1);
    set_rx(0, 1'b1);
    repeat (4) tick();
    check("break_exit", get_busy(0), 1'b0);
    send_frame(0, 8'h33, 0, 0, 0, 0);
    check("t3_flags", get_flags(0), 3'b000);
    drain(0, "t3");

    // Reset mid-frame with a sticky flag and a queued byte present.
    send_frame(0, 8'hC3, 0, 1, 0, 0);
    send_frame(0, 8'h77, 0, 0, 0, 0);
    check("pre_rst_flags", get_flags(0), 3'b100);
    check("pre_rst_count", get_count(0), 1);
    tick();
    set_rx(0, 1'b0);
    repeat (C_A) tick();
    for (int i = 0; i < 4; i++) begin
      set_rx(0, (8'hA5 >> i) & 1);
      repeat (C_A) tick();
    end
    set_rx(0, 1'b1);
    repeat (C_A / 2) tick();
    check("mid_busy", get_busy(0), 1'b1);
    apply_reset(0);
    check_reset_state(0, "midrst");
    send_frame(0, 8'h5A, 0, 0, 0, 0);
    check("t6_flags", get_flags(0), 3'b000);
    drain(0, "t6");

    // Even parity: good byte kept, bad parity dropped, clear_err works.
    send_frame(1, 8'h55, 0, 0, 0, 0);
    send_frame(1, 8'h55, 1, 0, 0, 0);
    check("par_flags", get_flags(1), 3'b010);
    check("par_count", get_count(1), 1);
    pulse_clear(1);
    check("par_cleared", get_flags(1), 3'b000);
    drain(1, "par");

    // Second stop bit low: frame error, byte discarded.
    send_frame(1, 8'h3C, 0, 1, 0, 0);
    check("stop2_flags", get_flags(1), 3'b100);
    check("stop2_count", get_count(1), 0);
    pulse_clear(1);

    // Overflow a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) send_frame(1, 8'(i * 8'h11), 0, 0, 0, 0);
    check("ovr_count", get_count(1), 4);
    check("ovr_full",  get_full(1),  1'b1);
    check("ovr_flags", get_flags(1), 3'b001);
    drain(1, "ovr");
    pulse_clear(1);
    check("ovr_cleared", get_flags(1), 3'b000);

    // Same, but pop on the cycle of the fifth push: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(1, 8'(i * 8'h11), 0, 0, 0, 0);
    send_frame(1, 8'h55, 0, 0, 1, 0);
    check("popush_count", get_count(1), 4);
    check("popush_full",  get_full(1),  1'b1);
    check("popush_flags", get_flags(1), 3'b000);
    drain(1, "popush");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
